// File: rtl/countdown_timer.sv
// Loadable minutes:seconds countdown timer with a one-second prescaler,
// pause/resume, expiry flag and a one-cycle done pulse on reaching 00:00.
module countdown_timer #(
  parameter int TICK_DIV = 5,
  parameter int MAX_MIN  = 59
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] min_out,
  output logic [7:0] sec_out,
  output logic       running,
  output logic       expired,
  output logic       done
);

  localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    MIN_CAP  = 8'(MAX_MIN);
  localparam logic [7:0]    SEC_CAP  = 8'd59;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t        state, state_nxt;
  logic [7:0]    min_q, min_nxt;
  logic [7:0]    sec_q, sec_nxt;
  logic [PW-1:0] pre_q, pre_nxt;
  logic          done_q, done_nxt;
  logic          time_nz;

  assign time_nz = (min_q != 8'd0) || (sec_q != 8'd0);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_nxt = state;
    min_nxt   = min_q;
    sec_nxt   = sec_q;
    pre_nxt   = pre_q;

    if (load) begin
      min_nxt   = (load_min > MIN_CAP) ? MIN_CAP : load_min;
      sec_nxt   = (load_sec > SEC_CAP) ? SEC_CAP : load_sec;
      pre_nxt   = '0;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!stop && start && time_nz) begin
            state_nxt = RUN;
            pre_nxt   = '0;
          end
        end
        RUN: begin
          // A stop on a due tick swallows that tick; the prescaler holds.
          if (stop) begin
            state_nxt = PAUSE;
          end else if (pre_q == PRE_LAST) begin
            pre_nxt = '0;
            if (sec_q != 8'd0) begin
              sec_nxt = sec_q - 8'd1;
            end else begin
              sec_nxt = SEC_CAP;
              min_nxt = min_q - 8'd1;
            end
            if (min_q == 8'd0 && sec_q <= 8'd1) begin
              min_nxt   = 8'd0;
              sec_nxt   = 8'd0;
              state_nxt = EXPIRED;
            end
          end else begin
            pre_nxt = pre_q + PW'(1);
          end
        end
        PAUSE: begin
          if (!stop && start) state_nxt = RUN;
        end
        EXPIRED: begin
          if (stop) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end

    done_nxt = (state_nxt == EXPIRED) && (state != EXPIRED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      min_q  <= 8'd0;
      sec_q  <= 8'd0;
      pre_q  <= '0;
      done_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state  <= state_nxt;
      min_q  <= min_nxt;
      sec_q  <= sec_nxt;
      pre_q  <= pre_nxt;
      done_q <= done_nxt;
    end
  end

  assign min_out = min_q;
  assign sec_out = sec_q;
  assign running = (state == RUN);
  assign expired = (state == EXPIRED);
  assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a vector table for load/priority/expiry
// plus hand-written countdown, borrow, pause and async-reset sequences.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load, start, stop;
  logic [7:0] load_min, load_sec;
  logic [7:0] min_out, sec_out;
  logic       running, expired, done;

  int n_cmp  = 0;
  int n_fail = 0;

  countdown_timer #(.TICK_DIV(5), .MAX_MIN(59)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_min (load_min),
    .load_sec (load_sec),
    .start    (start),
    .stop     (stop),
    .min_out  (min_out),
    .sec_out  (sec_out),
    .running  (running),
    .expired  (expired),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [7:0] lm;
    logic [7:0] ls;
    logic       st;
    logic       sp;
    logic [7:0] em;
    logic [7:0] es;
    logic       er;
    logic       ee;
    logic       ed;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic ld, input int lm, input int ls,
                              input logic st, input logic sp,
                              input int em, input int es,
                              input logic er, input logic ee, input logic ed);
    vec_t v;
    v.ld = ld; v.lm = 8'(lm); v.ls = 8'(ls); v.st = st; v.sp = sp;
    v.em = 8'(em); v.es = 8'(es); v.er = er; v.ee = ee; v.ed = ed;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int em, input int es,
                           input logic er, input logic ee, input logic ed);
    check({tag, ".min"},     int'(min_out), em);
    check({tag, ".sec"},     int'(sec_out), es);
    check({tag, ".running"}, int'(running), int'(er));
    check({tag, ".expired"}, int'(expired), int'(ee));
    check({tag, ".done"},    int'(done),    int'(ed));
  endtask

  task automatic drive(input logic ld, input int lm, input int ls,
                       input logic st, input logic sp);
    load = ld; load_min = 8'(lm); load_sec = 8'(ls); start = st; stop = sp;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load 00:03, start at edge N, follow every edge through N+16.
  task automatic run_three(input string tag);
    drive(1, 0, 3, 0, 0); step();
    check_out({tag, ".load"}, 0, 3, 0, 0, 0);
    drive(0, 0, 0, 1, 0); step();
    check_out({tag, ".start"}, 0, 3, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      step();
      check_out($sformatf("%s.n+%0d", tag, k), 0, 3 - k / 5, k < 15, k >= 15, k == 15);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #2;
    check_out("reset_async", 0, 0, 0, 0, 0);
    step(); step();
    reset_n = 1'b1;
    step();
    check_out("after_reset", 0, 0, 0, 0, 0);

    //          ld  lm  ls st sp   em  es  run exp done
    tbl.push_back(mk(0,  0,  0, 1, 0,   0,  0, 0, 0, 0)); // start at 00:00 ignored
    tbl.push_back(mk(1, 99, 75, 0, 0,  59, 59, 0, 0, 0)); // clamp both fields
    tbl.push_back(mk(1,  3,  7, 1, 0,   3,  7, 0, 0, 0)); // load beats start
    tbl.push_back(mk(1,  0, 60, 0, 0,   0, 59, 0, 0, 0)); // sec clamp edge
    tbl.push_back(mk(1, 59, 59, 0, 0,  59, 59, 0, 0, 0)); // exact maxima
    tbl.push_back(mk(1,  0,  2, 0, 1,   0,  2, 0, 0, 0)); // load beats stop
    tbl.push_back(mk(0,  0,  0, 1, 0,   0,  2, 1, 0, 0)); // start, prescaler 0
    tbl.push_back(mk(0,  0,  0, 0, 0,   0,  2, 1, 0, 0)); // 1
    tbl.push_back(mk(0,  0,  0, 1, 0,   0,  2, 1, 0, 0)); // 2, start in RUN no-op
    tbl.push_back(mk(0,  0,  0, 0, 0,   0,  2, 1, 0, 0)); // 3
    tbl.push_back(mk(0,  0,  0, 0, 0,   0,  2, 1, 0, 0)); // 4
    tbl.push_back(mk(0,  0,  0, 0, 0,   0,  1, 1, 0, 0)); // tick
    tbl.push_back(mk(0,  0,  0, 1, 1,   0,  1, 0, 0, 0)); // stop beats start
    tbl.push_back(mk(0,  0,  0, 0, 1,   0,  1, 0, 0, 0)); // stop held in PAUSE
    tbl.push_back(mk(0,  0,  0, 1, 0,   0,  1, 1, 0, 0)); // resume at prescaler 0
    tbl.push_back(mk(0,  0,  0, 0, 0,   0,  1, 1, 0, 0));
    tbl.push_back(mk(0,  0,  0, 0, 0,   0,  1, 1, 0, 0));
    tbl.push_back(mk(0,  0,  0, 0, 0,   0,  1, 1, 0, 0));
    tbl.push_back(mk(0,  0,  0, 0, 0,   0,  1, 1, 0, 0));
    tbl.push_back(mk(0,  0,  0, 0, 0,   0,  0, 0, 1, 1)); // expiry, done pulse
    tbl.push_back(mk(0,  0,  0, 0, 0,   0,  0, 0, 1, 0)); // done drops
    tbl.push_back(mk(0,  0,  0, 1, 0,   0,  0, 0, 1, 0)); // start ignored
    tbl.push_back(mk(0,  0,  0, 0, 1,   0,  0, 0, 0, 0)); // stop acknowledges
    tbl.push_back(mk(1,  1,  0, 1, 1,   1,  0, 0, 0, 0)); // load beats all

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ld, int'(tbl[i].lm), int'(tbl[i].ls), tbl[i].st, tbl[i].sp);
      step();
      check_out($sformatf("vec%0d", i), int'(tbl[i].em), int'(tbl[i].es),
                tbl[i].er, tbl[i].ee, tbl[i].ed);
    end

    run_three("basic");

    // Borrow from 01:00 and full-length expiry.
    begin
      int k;
      drive(1, 1, 0, 0, 0); step();
      drive(0, 0, 0, 1, 0); step();
      drive(0, 0, 0, 0, 0);
      for (int j = 1; j <= 4; j++) step();
      check_out("borrow.pre", 1, 0, 1, 0, 0);
      step();
      check_out("borrow.tick", 0, 59, 1, 0, 0);
      k = 5;
      while (!expired && k < 400) begin
        step();
        k++;
      end
      check("borrow.expiry_edge", k, 300);
      check_out("borrow.expired", 0, 0, 0, 1, 1);
    end

    // Pause at prescaler 2 for 7 cycles, then resume.
    drive(1, 0, 10, 0, 0); step();
    drive(0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0); step(); step();
    drive(0, 0, 0, 0, 1);
    for (int j = 0; j < 7; j++) begin
      step();
      check_out($sformatf("pause.p%0d", j), 0, 10, 0, 0, 0);
    end
    drive(0, 0, 0, 1, 0); step();
    check_out("pause.resume", 0, 10, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    step(); check_out("pause.r1", 0, 10, 1, 0, 0);
    step(); check_out("pause.r2", 0, 10, 1, 0, 0);
    step(); check_out("pause.r3", 0, 9, 1, 0, 0);
    for (int j = 1; j <= 4; j++) step();
    check_out("pause.r7", 0, 9, 1, 0, 0);
    step(); check_out("pause.r8", 0, 8, 1, 0, 0);

    // Asynchronous reset between edges during RUN.
    drive(1, 0, 3, 0, 0); step();
    drive(0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0); step(); step();
    check_out("areset.before", 0, 3, 1, 0, 0);
    #3;
    reset_n = 1'b0;
    #1;
    check_out("areset.now", 0, 0, 0, 0, 0);
    step(); check_out("areset.hold1", 0, 0, 0, 0, 0);
    step(); check_out("areset.hold2", 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    step(); check_out("areset.release", 0, 0, 0, 0, 0);
    run_three("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable minutes:seconds countdown timer. It is the down-counting counterpart of the clock's rollover counters: instead of counting up and rolling over, it counts down from a preset time with seconds-to-minutes borrow and flags expiry at 00:00. It sits beside the time-of-day chain, is driven from the same clock, and feeds the display mux and the alarm/buzzer logic.

## Interface
- TICK_DIV, 5: clk cycles per one-second decrement; legal range ≥1, and 1 means decrement every cycle.
- MAX_MIN, 59: largest loadable minutes value, ≤255.
- clk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset; all state clears immediately on assertion.
- load  in  1  loads load_min/load_sec and forces IDLE.
- load_min  in  8  preset minutes.
- load_sec  in  8  preset seconds.
- start  in  1  begins or resumes the countdown.
- stop  in  1  pauses the countdown; in EXPIRED it acknowledges expiry.
- min_out  out  8  current minutes.
- sec_out  out  8  current seconds, 0..59.
- running  out  1  high while in RUN.
- expired  out  1  high while in EXPIRED.
- done  out  1  one-cycle pulse on entry to EXPIRED.

## Operation
- States:
  - IDLE (reset state)
  - RUN
  - PAUSE
  - EXPIRED
- Priority among inputs sampled on the same edge: load > stop > start.
- load, in any state:
  - min_out ← min(load_min, MAX_MIN); sec_out ← min(load_sec, 59).
  - Prescaler clears, state goes to IDLE, done stays low.
- IDLE + start:
  - If the current time ≠ 00:00: go to RUN and clear the prescaler.
  - If the time is 00:00: start is ignored and the state stays IDLE.
- RUN:
  - The prescaler counts 0..TICK_DIV-1.
  - On the edge where prescaler = TICK_DIV-1, the prescaler returns to 0 and the time decrements.
- Decrement rules:
  - If sec > 0: sec − 1.
  - Else: sec ← 59 and min − 1 (borrow).
  - A decrement that produces 00:00 moves the state to EXPIRED on that same edge.
- RUN + stop: go to PAUSE. The prescaler holds its value, and no decrement happens on that edge even if the tick was due.
- PAUSE + start: go to RUN. The prescaler resumes from its held value and is not cleared.
- EXPIRED:
  - Time holds at 00:00 and start is ignored.
  - stop returns to IDLE; load also exits, as above.
- Outputs:
  - running = (state == RUN); expired = (state == EXPIRED). Both are registered/state-decoded, not combinational from inputs.
  - done is high for exactly the one cycle following the edge that enters EXPIRED.
- Width rules: min and sec are 8-bit unsigned. The prescaler is wide enough for TICK_DIV-1. No value ever wraps below 00:00.

## Timing
- Reset:
  - min_out=0, sec_out=0, running=0, expired=0, done=0, state IDLE, prescaler 0.
  - Outputs take these values immediately on reset_n falling, independent of clk.
- Reset mid-RUN aborts the countdown with no done pulse.
- Input latency: load, start and stop take effect on the edge that samples them, with outputs visible after that edge.
- Decrement timing: if start is sampled at edge N, the first decrement occurs at edge N+TICK_DIV and subsequent ones every TICK_DIV edges.
- Expiry timing: with a preset of S total seconds and no pauses, EXPIRED is entered at edge N+S·TICK_DIV. done is high from that edge until the next edge.
- Pause timing: time spent in PAUSE shifts all later decrements by exactly the paused cycle count.

## Test plan
- TICK_DIV=5: reset, load 00:03, start at edge N.
  - sec_out goes 3→2→1→0 at edges N+5, N+10 and N+15.
  - expired=1 and done pulses for one cycle after N+15; running=0 afterward.
- Borrow: load 01:00, start.
  - After 5 cycles, min_out=0 and sec_out=59.
  - Continuing with no stop reaches EXPIRED after 60 ticks in total.
- Pause: load 00:10, start, assert stop at prescaler=2 for 7 cycles, then start.
  - No decrement occurs during PAUSE.
  - The first decrement lands 3 cycles after resume (the remaining prescaler count: prescaler 2 → 3 → 4 → decrement).
- Clamp and priority:
  - load 99:75 with MAX_MIN=59 → outputs 59:59.
  - load and start asserted on the same edge → IDLE with the loaded value, running=0.
  - start at 00:00 → stays IDLE.
- Expiry acknowledge: in EXPIRED, start → no change; stop → IDLE with expired=0.
- Asynchronous reset: drop reset_n mid-RUN between clock edges.
  - All outputs are 0 immediately and no done pulse occurs.
  - After release, a fresh load/start behaves exactly as in the first scenario.
